opl_acc: RTL and testbench
==========================

Name: opl_acc

Overview:
Per-frame output mixer for the OPL FM core. It sums the signed operator results of the 9 channels over one 18-slot frame. Carrier and additive outputs count once; rhythm-mode percussion outputs count twice. Each add saturates. At every frame boundary it presents the finished 16-bit signed sample. It sits after the operator stage and drives the core's `snd` output.

Parameters:
- INW, 13, width of the signed operator result.
- OUTW, 16, width of the signed accumulator and of `snd`.

Ports:
- clk  in  1  system clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- cenop  in  1  operator clock enable; all state advances only when cenop=1.
- zero  in  1  one-cenop pulse marking slot 0, i.e. the first slot of a frame.
- slot  in  18  one-hot current slot. Index = group*6 + op*3 + sub; channel = group*3 + sub.
- rhy_en  in  1  rhythm (percussion) mode enable.
- op_result  in  INW  signed operator output, aligned with `slot`.
- op  in  1  1 = operator is the carrier (op1), 0 = modulator (op0); aligned with `slot`.
- con  in  1  channel connection bit: 1 = additive, so both operators are audible.
- snd  out  OUTW  signed mixed sample, held for one frame.

Behaviour:
- Reset: acc=0, snd=0. Reset takes effect on any clk edge regardless of cenop. A reset mid-frame discards the partial sum.
- No state change when cenop=0.
- sum_en, normal slot:
  - rhy_en=0, or slot in 0..11: sum_en = op | con.
  - rhy_en=1 and slot in 12..17, fixed map:
    - slot12 (BD modulator): 0.
    - slot15 (BD carrier): 1.
    - slot13 (HH), slot16 (SD), slot14 (TOM), slot17 (CYM): 1. `con` and `op` are ignored for these.
- Doubling: when rhy_en=1 and slot in 12..17, the value is op_result sign-extended to INW+1 bits and shifted left by 1. Otherwise it is op_result sign-extended.
- Value is sign-extended to OUTW before adding.
- Saturation: each addition saturates to [-32768, +32767], detected by the sign-overflow rule. Once saturated, later opposite-sign terms move the value back from the limit.
- Frame boundary, cenop=1 and zero=1, in the same cycle:
  - snd <= acc, the completed previous frame.
  - acc <= (sum_en ? value : 0), the first term of the new frame.
- Other cenop=1 cycles: acc <= sum_en ? sat(acc + value) : acc.
- Latency: a frame's sum appears on `snd` on the cenop edge where the next zero is sampled. snd then holds for 18 cenop cycles.
- slot all-zero or multi-hot (illegal): treat as a non-rhythm slot.
- A zero pulse without cenop is ignored.

Decomposition:
- Shared package: SLOT_BD0=12, SLOT_HH=13, SLOT_TOM=14, SLOT_BD1=15, SLOT_SD=16, SLOT_CYM=17, NUM_SLOTS=18.
- One sub-module, opl_single_acc (params INW, OUTW). Ports: clk, rst, cenop, zero, sum_en, op_result, snd. It contains the saturating accumulator and the frame latch.
- opl_acc contains only the sum_en/doubling decode and instantiates opl_single_acc.

Test Plan:
- Reset: assert rst over 3 cenop cycles -> snd=0. After release, first zero with all sum_en=0 -> snd=0.
- Normal mode, rhy_en=0, con=0: op_result=100 on every slot, op=1 on the 9 carrier slots -> next zero gives snd=900.
- Additive: as above with con=1 on channel 0 (slots 0 and 3 both summed, others carrier-only) -> snd=1000.
- Rhythm: rhy_en=1, op_result=100 everywhere, carriers only on ch0-5 (6 terms) -> snd = 600 + 5*200 = 1600. Slot12 is excluded.
- Positive saturation: rhy_en=1, op_result=4095 on all slots, con=1 -> snd=32767. Negative: op_result=-4096 -> snd=-32768.
- cenop gating and mid-frame reset: toggle cenop at 1/3 duty -> snd identical to the cenop=1 run. Reset at slot 8 -> partial sum discarded, next frame correct.

Source files
------------

// File: rtl/opl_acc_pkg.sv
// Shared slot map and helpers for the OPL output mixer.
// Slot index = group*6 + op*3 + sub; the rhythm instruments occupy slots 12..17.
package opl_acc_pkg;

  localparam int NUM_SLOTS = 18;
  localparam int SLOT_BD0  = 12;
  localparam int SLOT_HH   = 13;
  localparam int SLOT_TOM  = 14;
  localparam int SLOT_BD1  = 15;
  localparam int SLOT_SD   = 16;
  localparam int SLOT_CYM  = 17;

  // True when exactly one slot bit is set.
  function automatic logic slot_onehot(input logic [NUM_SLOTS-1:0] s);
    return (s != '0) && ((s & (s - NUM_SLOTS'(1))) == '0);
  endfunction

endpackage

// File: rtl/opl_single_acc.sv
// Saturating frame accumulator plus the latch that holds the finished sample on snd.
// One cenop of latency from zero to snd update; no backpressure, state frozen while cenop=0.
module opl_single_acc #(
  parameter int INW  = 13,
  parameter int OUTW = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cenop,
  input  logic                   zero,
  input  logic                   sum_en,
  input  logic signed [INW:0]    op_result,
  output logic signed [OUTW-1:0] snd
);

  localparam logic signed [OUTW-1:0] SAT_MAX = {1'b0, {(OUTW-1){1'b1}}};
  localparam logic signed [OUTW-1:0] SAT_MIN = {1'b1, {(OUTW-1){1'b0}}};

  logic signed [OUTW-1:0] acc;
  logic signed [OUTW-1:0] ext;
  logic signed [OUTW-1:0] sum;
  logic signed [OUTW-1:0] sat;
  logic                   ovf;

  assign ext = {{(OUTW-INW-1){op_result[INW]}}, op_result};

  // Overflow only when both addends share a sign and the result does not.
  always_comb begin
    sum = acc + ext;
    ovf = (acc[OUTW-1] == ext[OUTW-1]) && (sum[OUTW-1] != acc[OUTW-1]);
    sat = sum;
    if (ovf) sat = ext[OUTW-1] ? SAT_MIN : SAT_MAX;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      snd <= '0;
    end else if (cenop) begin
      if (zero) begin
        snd <= acc;
        acc <= sum_en ? ext : '0;
      end else if (sum_en) begin
        acc <= sat;
      end
    end
  end

endmodule

// File: rtl/opl_acc.sv
// Per-frame OPL mixer: decides which slots are audible and doubles rhythm outputs.
// Sample appears on snd at the cenop edge that samples the next zero; no backpressure.
module opl_acc
  import opl_acc_pkg::*;
#(
  parameter int INW  = 13,
  parameter int OUTW = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cenop,
  input  logic                   zero,
  input  logic [NUM_SLOTS-1:0]   slot,
  input  logic                   rhy_en,
  input  logic signed [INW-1:0]  op_result,
  input  logic                   op,
  input  logic                   con,
  output logic signed [OUTW-1:0] snd
);

  logic               rhy_slot;
  logic               sum_en;
  logic signed [INW:0] value;

  // Illegal (zero or multi-hot) slot vectors fall back to the melodic path.
  assign rhy_slot = rhy_en && slot_onehot(slot) && (|slot[SLOT_CYM:SLOT_BD0]);

  always_comb begin
    sum_en = op | con;
    value  = {op_result[INW-1], op_result};
    if (rhy_slot) begin
      sum_en = !slot[SLOT_BD0];
      value  = {op_result, 1'b0};
    end
  end

  opl_single_acc #(
    .INW  (INW),
    .OUTW (OUTW)
  ) u_acc (
    .clk       (clk),
    .rst       (rst),
    .cenop     (cenop),
    .zero      (zero),
    .sum_en    (sum_en),
    .op_result (value),
    .snd       (snd)
  );

endmodule

// File: tb/tb_opl_acc.sv
// Directed frames for opl_acc; expected samples are queued per frame and
// checked by a monitor at each cenop&zero edge.
module tb_opl_acc;

  logic               clk = 1'b0;
  logic               rst;
  logic               cenop;
  logic               zero;
  logic [17:0]        slot;
  logic               rhy_en;
  logic signed [12:0] op_result;
  logic               op;
  logic               con;
  logic signed [15:0] snd;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pops  = 0;
  logic signed [15:0] exp_q[$];

  opl_acc #(.INW(13), .OUTW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cenop     (cenop),
    .zero      (zero),
    .slot      (slot),
    .rhy_en    (rhy_en),
    .op_result (op_result),
    .op        (op),
    .con       (con),
    .snd       (snd)
  );

  always #5 clk = ~clk;

  // Monitor: every sampled frame boundary must produce the next queued sample.
  initial begin
    logic signed [15:0] e;
    forever begin
      @(posedge clk);
      if (cenop && zero && !rst) begin
        #1;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL snd_frame: got %0d, nothing expected", snd);
        end else begin
          e = exp_q.pop_front();
          n_pops++;
          if (snd !== e) begin
            n_fail++;
            $display("FAIL snd_frame%0d: got %0d, expected %0d", n_pops, snd, e);
          end
        end
      end
    end
  end

  task automatic check_snd(input string name, input logic signed [15:0] e);
    n_tests++;
    if (snd !== e) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, snd, e);
    end
  endtask

  // Drives one frame. Slots below split get v_a, the rest v_b; each slot is
  // preceded by gap idle (cenop=0) cycles; stop_at pulses reset on that slot.
  task automatic run_frame(input logic rhy, input logic op_en, input logic [8:0] con_mask,
                           input logic signed [12:0] v_a, input logic signed [12:0] v_b,
                           input int split, input int gap, input int stop_at);
    for (int i = 0; i < 18; i++) begin
      int ch;
      ch        = (i / 6) * 3 + (i % 3);
      slot      = 18'd1 << i;
      zero      = (i == 0);
      rhy_en    = rhy;
      op        = op_en && ((i % 6) >= 3);
      con       = con_mask[ch];
      op_result = (i < split) ? v_a : v_b;
      if (i == stop_at) begin
        rst   = 1'b1;
        cenop = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        cenop = 1'b0;
        zero  = 1'b0;
        return;
      end
      for (int g = 0; g < gap; g++) begin
        cenop = 1'b0;
        @(negedge clk);
      end
      cenop = 1'b1;
      @(negedge clk);
    end
    cenop = 1'b0;
    zero  = 1'b0;
  endtask

  task automatic flush_frame();
    slot      = 18'd1;
    zero      = 1'b1;
    op        = 1'b0;
    con       = 1'b0;
    rhy_en    = 1'b0;
    op_result = '0;
    cenop     = 1'b1;
    @(negedge clk);
    cenop = 1'b0;
    zero  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cenop = 1'b0; zero = 1'b0; slot = '0;
    rhy_en = 1'b0; op_result = '0; op = 1'b0; con = 1'b0;
    @(negedge clk);
    cenop = 1'b1;
    repeat (3) @(negedge clk);
    rst   = 1'b0;
    cenop = 1'b0;
    check_snd("reset_snd", 16'sd0);
    exp_q.push_back(16'sd0);

    run_frame(1'b0, 1'b0, 9'h000, 13'sd100, 13'sd100, 18, 0, -1);
    exp_q.push_back(16'sd0);
    run_frame(1'b0, 1'b1, 9'h000, 13'sd100, 13'sd100, 18, 0, -1);
    exp_q.push_back(16'sd900);
    run_frame(1'b0, 1'b1, 9'h001, 13'sd100, 13'sd100, 18, 0, -1);
    exp_q.push_back(16'sd1000);
    run_frame(1'b1, 1'b1, 9'h000, 13'sd100, 13'sd100, 18, 0, -1);
    exp_q.push_back(16'sd1600);
    run_frame(1'b1, 1'b1, 9'h1FF, 13'sd4095, 13'sd4095, 18, 0, -1);
    exp_q.push_back(16'sd32767);
    run_frame(1'b1, 1'b1, 9'h1FF, -13'sd4096, -13'sd4096, 18, 0, -1);
    exp_q.push_back(-16'sd32768);
    // 9*4095 clips at +32767, then nine -100 terms pull it back down.
    run_frame(1'b0, 1'b1, 9'h1FF, 13'sd4095, -13'sd100, 9, 0, -1);
    exp_q.push_back(16'sd31867);
    run_frame(1'b0, 1'b1, 9'h000, 13'sd100, 13'sd100, 18, 2, -1);
    exp_q.push_back(16'sd900);
    run_frame(1'b0, 1'b1, 9'h000, 13'sd100, 13'sd100, 18, 0, 8);
    check_snd("midframe_reset_snd", 16'sd0);
    exp_q.push_back(16'sd0);
    run_frame(1'b0, 1'b1, 9'h000, 13'sd100, 13'sd100, 18, 0, -1);
    exp_q.push_back(16'sd900);
    flush_frame();
    repeat (3) @(negedge clk);

    n_tests++;
    if (exp_q.size() != 0 || n_pops != 11) begin
      n_fail++;
      $display("FAIL frame_count: got %0d frames checked with %0d left, expected 11 and 0",
               n_pops, exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
